// File: rtl/cpu_mem_pkg.sv
// Shared constants and the loader state type for the memory responder.
package cpu_mem_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      HOLD,
      LOAD,
      RELEASE,
      RUN
   } state_t;

endpackage

// File: rtl/mem_dp_ram.sv
// Unified DEPTH x DATA_W memory: one write port and two registered read ports.
// Reads are read-first: a same-cycle write to the read address returns the old word.
module mem_dp_ram
   import cpu_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] addr_a,
   output logic [DATA_W-1:0] data_a,
   input  logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] data_b
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage array; contents survive reset so a loaded image is retained.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read registers; sampling the array before the write lands gives read-first behaviour.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_a <= '0;
         data_b <= '0;
      end else begin
         data_a <= mem[addr_a];
         data_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the pipelined core: serves fetch and data ports from a
// shared memory and runs the loader that streams an image in before releasing the core.
module cpu_mem_responder
   import cpu_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic              run_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic [ADDR_W:0]   load_count,
   output logic              cpu_rst_n,
   output logic [ADDR_W-1:0] start_pc,
   input  logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instr,
   input  logic [ADDR_W-1:0] ram_addr2,
   input  logic [DATA_W-1:0] ram_in2,
   input  logic              mem_w_en,
   output logic [DATA_W-1:0] ram_data2,
   output logic              running
);

   localparam logic [ADDR_W:0] COUNT_MAX  = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] COUNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] addr_ctr;
   logic [ADDR_W-1:0] start_pc_q;
   logic [ADDR_W:0]   count_q;
   logic              accept;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   assign accept     = load_ready & load_valid;
   assign load_count = count_q;
   assign start_pc   = start_pc_q;

   // Loader state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HOLD;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control outputs; load_start takes priority over run_start in HOLD.
   always_comb begin
      state_next = state;
      load_ready = 1'b0;
      cpu_rst_n  = 1'b0;
      running    = 1'b0;
      case (state)
         HOLD: begin
            if (load_start) begin
               state_next = LOAD;
            end else if (run_start) begin
               state_next = RELEASE;
            end
         end
         LOAD: begin
            load_ready = 1'b1;
            if (load_valid && (load_last || count_q == COUNT_LAST)) begin
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            state_next = RUN;
         end
         RUN: begin
            cpu_rst_n = 1'b1;
            running   = 1'b1;
         end
         default: begin
            state_next = HOLD;
         end
      endcase
   end

   // Load address, start PC and word counter; the address wraps and the count saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_ctr   <= '0;
         start_pc_q <= '0;
         count_q    <= '0;
      end else if (state == HOLD && load_start) begin
         addr_ctr   <= load_base;
         start_pc_q <= load_base;
         count_q    <= '0;
      end else if (accept) begin
         addr_ctr <= addr_ctr + 1'b1;
         if (count_q != COUNT_MAX) begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   // Single write port: loader owns it in LOAD, the core owns it in RUN, nothing during reset.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = ram_addr2;
      wr_data = ram_in2;
      if (!rst) begin
         if (accept) begin
            wr_en   = 1'b1;
            wr_addr = addr_ctr;
            wr_data = load_data;
         end else if (state == RUN && mem_w_en) begin
            wr_en = 1'b1;
         end
      end
   end

   mem_dp_ram u_ram (
      .clk    (clk),
      .rst    (rst),
      .we     (wr_en),
      .waddr  (wr_addr),
      .wdata  (wr_data),
      .addr_a (pc),
      .data_a (instr),
      .addr_b (ram_addr2),
      .data_b (ram_data2)
   );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed-plus-random bench for cpu_mem_responder with a word-array memory model.
module tb_cpu_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic        run_start;
   logic [6:0]  load_base;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic        load_last;
   logic [7:0]  load_count;
   logic        cpu_rst_n;
   logic [6:0]  start_pc;
   logic [6:0]  pc;
   logic [31:0] instr;
   logic [6:0]  ram_addr2;
   logic [31:0] ram_in2;
   logic        mem_w_en;
   logic [31:0] ram_data2;
   logic        running;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] ref_mem [128];
   logic [31:0] prog [3] = '{32'hE3A00001, 32'hE3A01002, 32'hE0802001};
   int          stall_pat [4] = '{1, 0, 0, 1};

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   cpu_mem_responder dut (
      .clk        (clk),
      .rst        (rst),
      .load_start (load_start),
      .run_start  (run_start),
      .load_base  (load_base),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_count (load_count),
      .cpu_rst_n  (cpu_rst_n),
      .start_pc   (start_pc),
      .pc         (pc),
      .instr      (instr),
      .ram_addr2  (ram_addr2),
      .ram_in2    (ram_in2),
      .mem_w_en   (mem_w_en),
      .ram_data2  (ram_data2),
      .running    (running)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkStatus(input string tag, input logic ready, input logic [7:0] count,
                              input logic rstn, input logic [6:0] spc, input logic run);
      checkOutput({tag, "_ready"},   32'(load_ready), 32'(ready));
      checkOutput({tag, "_count"},   32'(load_count), 32'(count));
      checkOutput({tag, "_rstn"},    32'(cpu_rst_n),  32'(rstn));
      checkOutput({tag, "_startpc"}, 32'(start_pc),   32'(spc));
      checkOutput({tag, "_running"}, 32'(running),    32'(run));
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_instr"}, instr,     32'h0);
      checkOutput({tag, "_data2"}, ram_data2, 32'h0);
      checkStatus(tag, 1'b0, 8'd0, 1'b0, 7'd0, 1'b0);
   endtask

   task automatic doReset(input string tag);
      rst        = 1'b1;
      load_start = 1'b0;
      run_start  = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
      mem_w_en   = 1'b0;
      applyStimulus();
      checkReset(tag);
      rst = 1'b0;
   endtask

   task automatic readBack(input string tag, input int addr_i, input int addr_d);
      pc        = 7'(addr_i);
      ram_addr2 = 7'(addr_d);
      mem_w_en  = 1'b0;
      applyStimulus();
      checkOutput({tag, "_instr"}, instr,     ref_mem[addr_i]);
      checkOutput({tag, "_data2"}, ram_data2, ref_mem[addr_d]);
   endtask

   initial begin
      int          acc;
      logic [31:0] d;
      int          a;
      int          p;
      logic        we;

      rst        = 1'b1;
      load_start = 1'b0;
      run_start  = 1'b0;
      load_base  = '0;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      pc         = '0;
      ram_addr2  = '0;
      ram_in2    = '0;
      mem_w_en   = 1'b0;
      applyStimulus();
      doReset("reset");

      // Basic load of three words at base 5.
      load_base  = 7'd5;
      load_start = 1'b1;
      applyStimulus();
      load_start = 1'b0;
      checkStatus("load1_enter", 1'b1, 8'd0, 1'b0, 7'd5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1;
         load_data  = prog[i];
         load_last  = (i == 2);
         applyStimulus();
         ref_mem[5 + i] = prog[i];
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      checkStatus("load1_release", 1'b0, 8'd3, 1'b0, 7'd5, 1'b0);
      applyStimulus();
      checkStatus("load1_run", 1'b0, 8'd3, 1'b1, 7'd5, 1'b1);
      readBack("load1_rb_a", 5, 6);
      readBack("load1_rb_b", 7, 5);
      ram_addr2 = 7'd22;
      ram_in2   = $urandom;
      mem_w_en  = 1'b1;
      applyStimulus();
      ref_mem[22] = ram_in2;
      mem_w_en    = 1'b0;

      // Handshake stall with load_last on the second accepted word.
      doReset("reset_stall");
      load_base  = 7'd20;
      load_start = 1'b1;
      applyStimulus();
      load_start = 1'b0;
      acc = 0;
      for (int j = 0; j < 4; j++) begin
         load_valid = (stall_pat[j] == 1);
         load_data  = $urandom;
         load_last  = (j == 3);
         checkOutput("stall_ready", 32'(load_ready), 32'd1);
         applyStimulus();
         if (stall_pat[j] == 1) begin
            ref_mem[20 + acc] = load_data;
            acc++;
         end
      end
      load_valid = 1'b1;
      load_last  = 1'b0;
      load_data  = $urandom;
      checkStatus("stall_release", 1'b0, 8'd2, 1'b0, 7'd20, 1'b0);
      applyStimulus();
      load_valid = 1'b0;
      checkStatus("stall_run", 1'b0, 8'd2, 1'b1, 7'd20, 1'b1);
      readBack("stall_rb", 20, 21);
      readBack("stall_untouched", 22, 22);

      // Wrap from 126 and saturate at 128 words with no load_last.
      doReset("reset_wrap");
      load_base  = 7'd126;
      load_start = 1'b1;
      applyStimulus();
      load_start = 1'b0;
      for (int i = 0; i < 130; i++) begin
         load_valid = 1'b1;
         load_last  = 1'b0;
         load_data  = $urandom;
         checkOutput("wrap_ready", 32'(load_ready), 32'(i < 128));
         applyStimulus();
         if (i < 128) begin
            ref_mem[(126 + i) % 128] = load_data;
         end
      end
      load_valid = 1'b0;
      checkStatus("wrap_run", 1'b0, 8'd128, 1'b1, 7'd126, 1'b1);
      for (int k = 0; k < 128; k++) begin
         readBack("wrap_rb", k, (k + 64) % 128);
      end

      // Read-first store followed by data and fetch reads of the new word.
      ram_addr2 = 7'h10;
      pc        = 7'h10;
      ram_in2   = 32'hDEADBEEF;
      mem_w_en  = 1'b1;
      applyStimulus();
      checkOutput("rf_old_data",  ram_data2, ref_mem[16]);
      checkOutput("rf_old_instr", instr,     ref_mem[16]);
      ref_mem[16] = 32'hDEADBEEF;
      mem_w_en    = 1'b0;
      applyStimulus();
      checkOutput("rf_new_data",  ram_data2, 32'hDEADBEEF);
      checkOutput("rf_new_instr", instr,     32'hDEADBEEF);

      // Random mix of core stores and reads in RUN.
      for (int n = 0; n < 60; n++) begin
         a  = int'($urandom_range(127));
         p  = int'($urandom_range(127));
         we = 1'($urandom_range(1));
         d  = $urandom;
         ram_addr2 = 7'(a);
         pc        = 7'(p);
         ram_in2   = d;
         mem_w_en  = we;
         applyStimulus();
         checkOutput("rnd_data2", ram_data2, ref_mem[a]);
         checkOutput("rnd_instr", instr,     ref_mem[p]);
         if (we) begin
            ref_mem[a] = d;
         end
      end
      mem_w_en = 1'b0;

      // Control requests are ignored once running.
      load_start = 1'b1;
      run_start  = 1'b1;
      applyStimulus();
      load_start = 1'b0;
      run_start  = 1'b0;
      checkStatus("run_ignore", 1'b0, 8'd128, 1'b1, 7'd126, 1'b1);

      // Stores in HOLD are dropped; run_start releases without loading.
      doReset("reset_hold");
      mem_w_en  = 1'b1;
      ram_addr2 = 7'd3;
      pc        = 7'd3;
      ram_in2   = 32'h12345678;
      applyStimulus();
      applyStimulus();
      checkOutput("hold_store_data",  ram_data2, ref_mem[3]);
      checkOutput("hold_store_instr", instr,     ref_mem[3]);
      mem_w_en  = 1'b0;
      run_start = 1'b1;
      applyStimulus();
      run_start = 1'b0;
      checkStatus("hold_release", 1'b0, 8'd0, 1'b0, 7'd0, 1'b0);
      applyStimulus();
      checkStatus("hold_run", 1'b0, 8'd0, 1'b1, 7'd0, 1'b1);
      readBack("hold_rb", 3, 3);

      // Reset in the middle of a load; simultaneous starts choose the load.
      doReset("reset_mid");
      load_base  = 7'd40;
      load_start = 1'b1;
      run_start  = 1'b1;
      applyStimulus();
      load_start = 1'b0;
      run_start  = 1'b0;
      checkStatus("mid_enter", 1'b1, 8'd0, 1'b0, 7'd40, 1'b0);
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1;
         load_last  = 1'b0;
         load_data  = $urandom;
         applyStimulus();
         ref_mem[40 + i] = load_data;
      end
      checkOutput("mid_count", 32'(load_count), 32'd2);
      rst       = 1'b1;
      load_data = $urandom;
      applyStimulus();
      checkReset("mid_reset");
      rst        = 1'b0;
      load_valid = 1'b0;
      applyStimulus();
      checkStatus("mid_hold", 1'b0, 8'd0, 1'b0, 7'd0, 1'b0);
      run_start = 1'b1;
      applyStimulus();
      run_start = 1'b0;
      applyStimulus();
      checkStatus("mid_run", 1'b0, 8'd0, 1'b1, 7'd0, 1'b1);
      readBack("mid_rb", 40, 41);
      readBack("mid_unwritten", 42, 42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the pipelined ARM32 core. It owns a unified 128x32 synchronous memory.
- It answers the core's instruction-fetch port and its data load/store port, each with a fixed 1-cycle read latency that matches the fetch-wait and memory-wait pipeline stages.
- A small loader FSM holds the core in reset, streams a program image into memory over a valid/ready handshake, then releases the core at a chosen start PC.

Parameters:
- ADDR_W, 7, word address width; shared by pc, ram_addr2 and start_pc.
- DATA_W, 32, word width.
- DEPTH, 128, number of words; always equals 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  in HOLD, begins an image load at load_base.
- run_start  in  1  in HOLD, releases the core without loading.
- load_base  in  ADDR_W  first load address; also becomes start_pc.
- load_valid  in  1  loader word valid.
- load_ready  out  1  responder accepts a loader word.
- load_data  in  DATA_W  loader word.
- load_last  in  1  marks the final loader word.
- load_count  out  ADDR_W+1  number of words accepted in the current or last load.
- cpu_rst_n  out  1  active-low reset to the core.
- start_pc  out  ADDR_W  start PC presented to the core.
- pc  in  ADDR_W  core fetch address.
- instr  out  DATA_W  fetched instruction, 1 cycle after pc.
- ram_addr2  in  ADDR_W  core data address.
- ram_in2  in  DATA_W  core store data.
- mem_w_en  in  1  core store enable.
- ram_data2  out  DATA_W  load data, 1 cycle after ram_addr2.
- running  out  1  high in RUN.

Behaviour:
- Reset (rst=1 at an edge):
  - state goes to HOLD.
  - Outputs: instr=0, ram_data2=0, cpu_rst_n=0, load_ready=0, start_pc=0, load_count=0, running=0.
  - Memory contents are not cleared.
  - Reset in the middle of a load returns to HOLD; words already written are retained.
- States:
  - HOLD: cpu_rst_n=0.
    - load_start: capture addr_ctr=load_base and start_pc=load_base, clear load_count, go to LOAD.
    - run_start alone: go to RELEASE.
    - load_start and run_start in the same cycle: load_start wins.
  - LOAD: load_ready=1, cpu_rst_n=0.
    - On each cycle with load_valid&load_ready: mem[addr_ctr]<=load_data, addr_ctr++, load_count++.
    - addr_ctr wraps from 127 to 0.
    - If the accepted word has load_last=1, or load_count reaches DEPTH, go to RELEASE. load_ready is 0 from the next cycle.
    - load_valid=0 simply stalls the FSM; there is no timeout.
  - RELEASE: exactly one cycle with cpu_rst_n=0 and start_pc stable, so the core samples start_pc. Then go to RUN.
  - RUN: cpu_rst_n=1, running=1.
    - Stays in RUN until rst; load_start and run_start are ignored.
- Core ports:
  - instr<=mem[pc] and ram_data2<=mem[ram_addr2] are registered every cycle in every non-reset state. Latency is exactly 1 cycle.
  - Stores: in RUN only, mem_w_en=1 writes mem[ram_addr2]<=ram_in2. mem_w_en is ignored outside RUN.
  - Read-during-write is read-first: same-cycle ram_data2 and instr for the written address return the old word; the new word is visible on the following read.
- Write arbitration: loader writes occur only in LOAD and core writes only in RUN, so the single write port never conflicts.
- Width rules: all addresses are unsigned modulo DEPTH. load_count saturates at DEPTH (128).

Decomposition:
- Package cpu_mem_pkg holds:
  - the state typedef enum {HOLD, LOAD, RELEASE, RUN};
  - the constants ADDR_W, DATA_W, DEPTH.
- One sub-module, mem_dp_ram: a DEPTH x DATA_W array with one write port and two registered read ports, read-first semantics.
- The FSM, counters and write mux live in cpu_mem_responder.

Test Plan:
- Reset then load, with load_base=5 and 3 words 0xE3A00001, 0xE3A01002, 0xE0802001 (last on the 3rd):
  - mem[5..7] hold those words; load_count=3.
  - Exactly one RELEASE cycle with cpu_rst_n=0 and start_pc=5, then cpu_rst_n=1 and running=1.
- Handshake stall: toggle load_valid 1,0,0,1 with load_last on the 2nd word.
  - Only 2 writes occur; load_ready drops the cycle after the last word is accepted.
- Wrap and saturate: load_base=126, stream 130 words with no load_last.
  - Words land at 126, 127, 0, ..., 125.
  - load_count stops at 128, and the FSM releases after word 128; words 129 and 130 are never accepted.
- RUN store/load: write 0xDEADBEEF to addr 0x10 while reading 0x10 in the same cycle.
  - ram_data2 returns the old value; next cycle it returns 0xDEADBEEF.
  - pc=0x10 in the following cycle gives instr=0xDEADBEEF one cycle later.
- Ignored stores: in HOLD, mem_w_en=1 with ram_addr2=3 and ram_in2=0x12345678.
  - mem[3] is unchanged; run_start then gives RELEASE, then RUN, with start_pc=0.
- Reset mid-load: assert rst after 2 of 4 words.
  - Returns to HOLD with all outputs at reset values; the 2 written words are still readable after run_start.
